// File: rtl/cic_comp_pkg.sv
// Shared types and elaboration-time helpers for the CIC compensation FIR.
// The FSM walks IDLE -> MAC -> FLUSH -> OUT once per decimated output.
package cic_comp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      FLUSH = 2'd2,
      OUT   = 2'd3
   } state_t;

   function automatic int clog2_l(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Wide enough that NUM_TAPS full-scale products can never overflow.
   function automatic int acc_width(input int inp_dw, input int coef_dw, input int num_taps);
      return inp_dw + coef_dw + clog2_l(num_taps);
   endfunction

endpackage

// File: rtl/cic_comp_fir_round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to OUT_DW.
// Purely combinational; the parent registers the result.
module round_sat #(
   parameter int ACC_DW    = 54,
   parameter int OUT_DW    = 32,
   parameter int OUT_SHIFT = 17
) (
   input  logic signed [ACC_DW-1:0] i_acc,
   output logic signed [OUT_DW-1:0] o_res
);

   // One guard bit above the accumulator so adding the rounding term cannot wrap.
   localparam int EW = (ACC_DW + 1 > OUT_DW) ? ACC_DW + 1 : OUT_DW;
   localparam int HS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic signed [EW-1:0] HALF = (OUT_SHIFT > 0) ? (EW'(1) << HS) : '0;
   localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
   localparam logic signed [EW-1:0] MINV = {{(EW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};

   logic signed [EW-1:0] w_ext;

   function automatic logic signed [EW-1:0] round_shr(input logic signed [EW-1:0] v);
      return (v + HALF) >>> OUT_SHIFT;
   endfunction

   function automatic logic signed [OUT_DW-1:0] saturate(input logic signed [EW-1:0] v);
      if (v > MAXV) begin
         return MAXV[OUT_DW-1:0];
      end else if (v < MINV) begin
         return MINV[OUT_DW-1:0];
      end
      return v[OUT_DW-1:0];
   endfunction

   assign w_ext = {{(EW-ACC_DW){i_acc[ACC_DW-1]}}, i_acc};
   assign o_res = saturate(round_shr(w_ext));

endmodule

// File: rtl/cic_comp_fir.sv
// Decimate-by-2 CIC droop-compensation FIR with one time-multiplexed MAC.
// Taps are read oldest-first so incoming writes only reuse slots already consumed.
module cic_comp_fir
   import cic_comp_pkg::*;
#(
   parameter int                            INP_DW    = 32,
   parameter int                            OUT_DW    = 32,
   parameter int                            COEF_DW   = 18,
   parameter int                            NUM_TAPS  = 16,
   parameter logic [COEF_DW*NUM_TAPS-1:0]   COEFFS    = '0,
   parameter int                            OUT_SHIFT = COEF_DW - 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [INP_DW-1:0] s_axis_in_tdata,
   input  logic                     s_axis_in_tvalid,
   output logic signed [OUT_DW-1:0] m_axis_out_tdata,
   output logic                     m_axis_out_tvalid,
   output logic                     overrun
);

   localparam int DEPTH   = NUM_TAPS + 2;
   localparam int PW      = clog2_l(DEPTH);
   localparam int TW      = clog2_l(NUM_TAPS);
   localparam int PROD_DW = INP_DW + COEF_DW;
   localparam int ACC_DW  = acc_width(INP_DW, COEF_DW, NUM_TAPS);
   localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
   localparam logic [TW-1:0] LAST_TAP  = TW'(NUM_TAPS - 1);

   state_t                     r_state, w_state_nxt;
   logic signed [INP_DW-1:0]   r_buf [DEPTH];
   logic [PW-1:0]              r_wr_ptr, r_rd_ptr;
   logic [TW-1:0]              r_tap;
   logic                       r_phase, r_trig, r_flush, r_overrun, r_tvalid;
   logic signed [OUT_DW-1:0]   r_tdata, w_res;
   logic signed [COEF_DW-1:0]  w_coef [NUM_TAPS];
   logic                       w_trig, w_accept;
   logic                       r_vld_p0, r_first_p0;
   logic signed [PROD_DW-1:0]  r_prod_p0;
   logic signed [ACC_DW-1:0]   r_acc_p1;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + 1'b1;
   endfunction

   // Slot of x[n-(NUM_TAPS-1)]: base - (NUM_TAPS-1) is base + 3 modulo NUM_TAPS+2.
   function automatic logic [PW-1:0] oldest_slot(input logic [PW-1:0] base);
      logic [PW:0] s;
      s = {1'b0, base} + (PW+1)'(3);
      return (s >= (PW+1)'(DEPTH)) ? PW'(s - (PW+1)'(DEPTH)) : s[PW-1:0];
   endfunction

   for (genvar i = 0; i < NUM_TAPS; i++) begin : g_coef
      assign w_coef[i] = COEFFS[COEF_DW*i +: COEF_DW];
   end

   assign w_trig   = s_axis_in_tvalid & ~r_phase;
   assign w_accept = w_trig & ((r_state == IDLE) | (r_state == OUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_buf[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_phase  <= 1'b0;
      end else if (s_axis_in_tvalid) begin
         r_buf[r_wr_ptr] <= s_axis_in_tdata;
         r_wr_ptr        <= ptr_inc(r_wr_ptr);
         r_phase         <= ~r_phase;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (r_trig) w_state_nxt = MAC;
         MAC:     if (r_tap == '0) w_state_nxt = FLUSH;
         FLUSH:   if (r_flush) w_state_nxt = OUT;
         OUT:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_trig     <= 1'b0;
         r_overrun  <= 1'b0;
         r_rd_ptr   <= '0;
         r_tap      <= '0;
         r_flush    <= 1'b0;
         r_vld_p0   <= 1'b0;
         r_first_p0 <= 1'b0;
         r_tvalid   <= 1'b0;
         r_tdata    <= '0;
      end else begin
         r_trig <= w_accept;
         if (w_trig & ~w_accept) begin
            r_overrun <= 1'b1;
         end
         if (w_accept) begin
            r_rd_ptr <= oldest_slot(r_wr_ptr);
            r_tap    <= LAST_TAP;
         end else if (r_state == MAC) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_tap    <= r_tap - 1'b1;
         end
         r_flush    <= (r_state == FLUSH) & ~r_flush;
         r_vld_p0   <= (r_state == MAC);
         r_first_p0 <= (r_state == MAC) & (r_tap == LAST_TAP);
         r_tvalid   <= (r_state == OUT);
         if (r_state == OUT) begin
            r_tdata <= w_res;
         end
      end
   end

   // Stage p0: one product per MAC cycle.
   always_ff @(posedge clk) begin
      r_prod_p0 <= PROD_DW'(r_buf[r_rd_ptr]) * PROD_DW'(w_coef[r_tap]);
   end

   // Stage p1: accumulate; the first tap of a computation restarts the sum.
   always_ff @(posedge clk) begin
      if (r_vld_p0) begin
         r_acc_p1 <= r_first_p0 ? ACC_DW'(r_prod_p0) : r_acc_p1 + ACC_DW'(r_prod_p0);
      end
   end

   round_sat #(
      .ACC_DW   (ACC_DW),
      .OUT_DW   (OUT_DW),
      .OUT_SHIFT(OUT_SHIFT)
   ) u_round_sat (
      .i_acc(r_acc_p1),
      .o_res(w_res)
   );

   assign m_axis_out_tdata  = r_tdata;
   assign m_axis_out_tvalid = r_tvalid;
   assign overrun           = r_overrun;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: three instances with ramp, flat and
// full-scale coefficient sets share one input stream.
module tb_cic_comp_fir;

   localparam int N = 16;

   function automatic logic [18*N-1:0] ramp_coeffs();
      logic [18*N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         r[18*i +: 18] = 18'(1000 * (i + 1));
      end
      return r;
   endfunction

   localparam logic [18*N-1:0] C_IMP = ramp_coeffs();
   localparam logic [18*N-1:0] C_DC  = {N{18'd8192}};
   localparam logic [18*N-1:0] C_SAT = {N{18'd131071}};

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [31:0] in_data = '0;
   logic               in_valid = 1'b0;
   logic signed [31:0] imp_tdata, dc_tdata, sat_tdata;
   logic               imp_tvalid, dc_tvalid, sat_tvalid;
   logic               imp_ovr, dc_ovr, sat_ovr;

   int          now_edge = 0;
   int          last_edge = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] q_imp[$];
   logic [31:0] q_dc[$];
   logic [31:0] q_sat[$];
   int          t_imp[$];

   cic_comp_fir #(.INP_DW(32), .OUT_DW(32), .COEF_DW(18), .NUM_TAPS(N), .COEFFS(C_IMP), .OUT_SHIFT(17)) u_imp (
      .clk(clk), .reset(reset), .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
      .m_axis_out_tdata(imp_tdata), .m_axis_out_tvalid(imp_tvalid), .overrun(imp_ovr));

   cic_comp_fir #(.INP_DW(32), .OUT_DW(32), .COEF_DW(18), .NUM_TAPS(N), .COEFFS(C_DC), .OUT_SHIFT(17)) u_dc (
      .clk(clk), .reset(reset), .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
      .m_axis_out_tdata(dc_tdata), .m_axis_out_tvalid(dc_tvalid), .overrun(dc_ovr));

   cic_comp_fir #(.INP_DW(32), .OUT_DW(32), .COEF_DW(18), .NUM_TAPS(N), .COEFFS(C_SAT), .OUT_SHIFT(17)) u_sat (
      .clk(clk), .reset(reset), .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
      .m_axis_out_tdata(sat_tdata), .m_axis_out_tvalid(sat_tvalid), .overrun(sat_ovr));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imp_tvalid) begin
         q_imp.push_back(imp_tdata);
         t_imp.push_back(now_edge);
      end
      if (dc_tvalid) q_dc.push_back(dc_tdata);
      if (sat_tvalid) q_sat.push_back(sat_tdata);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [31:0] out_at(input int which, input int idx);
      case (which)
         0:       return (idx < q_imp.size()) ? q_imp[idx] : 32'hxxxx_xxxx;
         1:       return (idx < q_dc.size())  ? q_dc[idx]  : 32'hxxxx_xxxx;
         default: return (idx < q_sat.size()) ? q_sat[idx] : 32'hxxxx_xxxx;
      endcase
   endfunction

   function automatic int time_at(input int idx);
      return (idx < t_imp.size()) ? t_imp[idx] : -1;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      now_edge++;
   endtask

   task automatic send(input logic [31:0] v, input int gap);
      in_data  = v;
      in_valid = 1'b1;
      cyc();
      last_edge = now_edge;
      in_valid  = 1'b0;
      in_data   = '0;
      repeat (gap - 1) cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
   endtask

   initial begin
      int base, t0, t10, t20;
      logic [31:0] v;

      do_reset();
      check("rst_tdata", imp_tdata, 32'd0);
      check("rst_tvalid", imp_tvalid, 1'b0);
      check("rst_overrun", imp_ovr, 1'b0);

      // Impulse through the ramp coefficients: odd taps appear, then zero.
      base = q_imp.size();
      send(32'd131072, 10);
      t0 = last_edge;
      for (int j = 1; j < 32; j++) send(32'd0, 10);
      repeat (30) cyc();
      check("imp_count", q_imp.size() - base, 16);
      check("imp_latency", time_at(base), t0 + 20);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("imp_out%0d", k), out_at(0, base + k), (k < 8) ? 32'(1000 * (2 * k + 1)) : 32'd0);
      end

      // DC gain with rounding during fill-up.
      do_reset();
      base = q_dc.size();
      for (int j = 0; j < 20; j++) send(32'd1000, 10);
      repeat (30) cyc();
      check("dc_count", q_dc.size() - base, 10);
      check("dc_out0", out_at(1, base + 0), 32'd63);
      check("dc_out1", out_at(1, base + 1), 32'd188);
      check("dc_out7", out_at(1, base + 7), 32'd938);
      check("dc_out8", out_at(1, base + 8), 32'd1000);
      check("dc_out9", out_at(1, base + 9), 32'd1000);

      // Positive and negative full scale.
      do_reset();
      base = q_sat.size();
      repeat (3) send(32'h7FFF_FFFF, 10);
      repeat (30) cyc();
      check("sat_pos_1tap", out_at(2, base + 0), 32'h7FFF_BFFF);
      check("sat_pos_clip", out_at(2, base + 1), 32'h7FFF_FFFF);
      do_reset();
      base = q_sat.size();
      repeat (3) send(32'h8000_0000, 10);
      repeat (30) cyc();
      check("sat_neg_1tap", out_at(2, base + 0), 32'h8000_4000);
      check("sat_neg_clip", out_at(2, base + 1), 32'h8000_0000);

      // Inputs every 2 cycles: only every fifth trigger is accepted.
      do_reset();
      check("ovr_after_reset", imp_ovr, 1'b0);
      base = q_imp.size();
      t0 = 0; t10 = 0; t20 = 0;
      for (int j = 0; j <= 20; j++) begin
         v = (j == 0 || j == 8) ? 32'd131072 : (j == 3) ? 32'd262144 : 32'd0;
         send(v, 2);
         if (j == 0) t0 = last_edge;
         if (j == 10) t10 = last_edge;
         if (j == 20) t20 = last_edge;
         if (j == 1) check("ovr_before_2nd", imp_ovr, 1'b0);
         if (j == 2) check("ovr_rise", imp_ovr, 1'b1);
      end
      repeat (30) cyc();
      check("ovr_count", q_imp.size() - base, 3);
      check("ovr_out0", out_at(0, base + 0), 32'd1000);
      check("ovr_out1", out_at(0, base + 1), 32'd30000);
      check("ovr_out2", out_at(0, base + 2), 32'd13000);
      check("ovr_t0", time_at(base + 0), t0 + 20);
      check("ovr_t1", time_at(base + 1), t10 + 20);
      check("ovr_t2", time_at(base + 2), t20 + 20);
      check("ovr_sticky", imp_ovr, 1'b1);

      // Reset in the middle of a computation.
      do_reset();
      base = q_imp.size();
      repeat (5) send(32'd131072, 1);
      repeat (4) cyc();
      check("midrst_ovr_pre", imp_ovr, 1'b1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("midrst_ovr_clr", imp_ovr, 1'b0);
      repeat (40) cyc();
      check("midrst_no_out", q_imp.size() - base, 0);
      send(32'd131072, 10);
      repeat (30) cyc();
      check("midrst_count", q_imp.size() - base, 1);
      check("midrst_out", out_at(0, base), 32'd1000);
      check("dc_ovr_end", dc_ovr, 1'b0);
      check("sat_ovr_end", sat_ovr, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
